register_scoreboard: RTL and testbench

//  Consumes per-instruction register-usage flags (GPR/FPR dest/src, EFLAGS read/write) at issue.

---
 rtl/register_scoreboard.sv | 123 ++++++++++++
 tb/tb_register_scoreboard.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/register_scoreboard.sv
// Register scoreboard: tracks in-flight writers per GPR, FPR and EFLAGS and
// withholds issue on RAW/WAW hazards until the matching writeback arrives.
module register_scoreboard #(
  parameter int NGPR    = 16,
  parameter int NFPR    = 16,
  parameter int IDX_W   = 4,
  parameter int STALL_W = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               iss_valid,
  input  logic [IDX_W-1:0]   iss_d,
  input  logic [IDX_W-1:0]   iss_s,
  input  logic [IDX_W-1:0]   iss_t,
  input  logic [9:0]         iss_use,
  output logic               iss_ready,
  input  logic               wb_g_valid,
  input  logic [IDX_W-1:0]   wb_g_idx,
  input  logic               wb_f_valid,
  input  logic [IDX_W-1:0]   wb_f_idx,
  input  logic               wb_ef_valid,
  input  logic               flush,
  output logic [NGPR-1:0]    busy_gpr,
  output logic [NFPR-1:0]    busy_fpr,
  output logic               busy_ef,
  output logic [STALL_W-1:0] stall_cnt
);

  logic [NGPR-1:0]    pend_g_q, pend_g_d, eff_g_s, wb_g_mask_s, set_g_mask_s;
  logic [NFPR-1:0]    pend_f_q, pend_f_d, eff_f_s, wb_f_mask_s, set_f_mask_s;
  logic               pend_ef_q, pend_ef_d, eff_ef_s;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               hazard_s, accept_s;

  logic from_gd, from_fd, to_gd, to_fd, from_gs, from_fs, from_gt, from_ft, from_ef, to_ef;
  assign {from_gd, from_fd, to_gd, to_fd, from_gs, from_fs, from_gt, from_ft, from_ef, to_ef} = iss_use;

  // Out-of-range indices read as "not pending" so their usage flags never stall.
  function automatic logic g_hit(input logic [NGPR-1:0] v, input logic [IDX_W-1:0] idx);
    if (int'(idx) < NGPR) g_hit = v[idx];
    else                  g_hit = 1'b0;
  endfunction

  function automatic logic f_hit(input logic [NFPR-1:0] v, input logic [IDX_W-1:0] idx);
    if (int'(idx) < NFPR) f_hit = v[idx];
    else                  f_hit = 1'b0;
  endfunction

  // Writeback clear masks and issue set masks; out-of-range indices are dropped.
  always_comb begin
    wb_g_mask_s  = '0;
    wb_f_mask_s  = '0;
    set_g_mask_s = '0;
    set_f_mask_s = '0;
    if (wb_g_valid && (int'(wb_g_idx) < NGPR)) wb_g_mask_s[wb_g_idx] = 1'b1;
    else                                        wb_g_mask_s = '0;
    if (wb_f_valid && (int'(wb_f_idx) < NFPR)) wb_f_mask_s[wb_f_idx] = 1'b1;
    else                                        wb_f_mask_s = '0;
    if (to_gd && (int'(iss_d) < NGPR)) set_g_mask_s[iss_d] = 1'b1;
    else                               set_g_mask_s = '0;
    if (to_fd && (int'(iss_d) < NFPR)) set_f_mask_s[iss_d] = 1'b1;
    else                               set_f_mask_s = '0;
  end

  // Same-cycle writeback bypass: a clearing writer no longer blocks a consumer.
  assign eff_g_s  = pend_g_q & ~wb_g_mask_s;
  assign eff_f_s  = pend_f_q & ~wb_f_mask_s;
  assign eff_ef_s = pend_ef_q & ~wb_ef_valid;

  assign hazard_s = (from_gd & g_hit(eff_g_s, iss_d)) | (from_gs & g_hit(eff_g_s, iss_s))
                  | (from_gt & g_hit(eff_g_s, iss_t)) | (from_fd & f_hit(eff_f_s, iss_d))
                  | (from_fs & f_hit(eff_f_s, iss_s)) | (from_ft & f_hit(eff_f_s, iss_t))
                  | (from_ef & eff_ef_s)
                  | (to_gd & g_hit(eff_g_s, iss_d)) | (to_fd & f_hit(eff_f_s, iss_d))
                  | (to_ef & eff_ef_s);

  assign iss_ready = ~flush & ~hazard_s;
  assign accept_s  = iss_valid & iss_ready;

  // Next pending state (set wins over clear) and saturating stall counter.
  always_comb begin
    pend_g_d    = '0;
    pend_f_d    = '0;
    pend_ef_d   = 1'b0;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      pend_g_d  = '0;
      pend_f_d  = '0;
      pend_ef_d = 1'b0;
    end else if (accept_s) begin
      pend_g_d  = eff_g_s | set_g_mask_s;
      pend_f_d  = eff_f_s | set_f_mask_s;
      pend_ef_d = eff_ef_s | to_ef;
    end else begin
      pend_g_d  = eff_g_s;
      pend_f_d  = eff_f_s;
      pend_ef_d = eff_ef_s;
    end
    if (iss_valid && !iss_ready && (stall_cnt_q != {STALL_W{1'b1}})) stall_cnt_d = stall_cnt_q + STALL_W'(1);
    else                                                             stall_cnt_d = stall_cnt_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend_g_q    <= '0;
      pend_f_q    <= '0;
      pend_ef_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      pend_g_q    <= pend_g_d;
      pend_f_q    <= pend_f_d;
      pend_ef_q   <= pend_ef_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy_gpr  = pend_g_q;
  assign busy_fpr  = pend_f_q;
  assign busy_ef   = pend_ef_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed self-checking bench for register_scoreboard (STALL_W=4 so the
// saturating counter limit is reachable quickly).
module tb_register_scoreboard;

  localparam int IDX_W = 4;
  localparam int SW    = 4;

  localparam logic [9:0] U_FGD = 10'b10_0000_0000;
  localparam logic [9:0] U_FFD = 10'b01_0000_0000;
  localparam logic [9:0] U_TGD = 10'b00_1000_0000;
  localparam logic [9:0] U_TFD = 10'b00_0100_0000;
  localparam logic [9:0] U_FGS = 10'b00_0010_0000;
  localparam logic [9:0] U_FFS = 10'b00_0001_0000;
  localparam logic [9:0] U_FGT = 10'b00_0000_1000;
  localparam logic [9:0] U_FEF = 10'b00_0000_0010;
  localparam logic [9:0] U_TEF = 10'b00_0000_0001;

  logic             clk = 1'b0;
  logic             rstn;
  logic             iss_valid;
  logic [IDX_W-1:0] iss_d, iss_s, iss_t;
  logic [9:0]       iss_use;
  logic             iss_ready;
  logic             wb_g_valid, wb_f_valid, wb_ef_valid, flush;
  logic [IDX_W-1:0] wb_g_idx, wb_f_idx;
  logic [15:0]      busy_gpr, busy_fpr;
  logic             busy_ef;
  logic [SW-1:0]    stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  register_scoreboard #(.NGPR(16), .NFPR(16), .IDX_W(IDX_W), .STALL_W(SW)) dut (
    .clk(clk), .rstn(rstn), .iss_valid(iss_valid), .iss_d(iss_d), .iss_s(iss_s),
    .iss_t(iss_t), .iss_use(iss_use), .iss_ready(iss_ready), .wb_g_valid(wb_g_valid),
    .wb_g_idx(wb_g_idx), .wb_f_valid(wb_f_valid), .wb_f_idx(wb_f_idx),
    .wb_ef_valid(wb_ef_valid), .flush(flush), .busy_gpr(busy_gpr), .busy_fpr(busy_fpr),
    .busy_ef(busy_ef), .stall_cnt(stall_cnt)
  );

  task automatic idle();
    iss_valid = 1'b0; iss_d = 4'd0; iss_s = 4'd0; iss_t = 4'd0; iss_use = 10'd0;
    wb_g_valid = 1'b0; wb_g_idx = 4'd0; wb_f_valid = 1'b0; wb_f_idx = 4'd0;
    wb_ef_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic issue(input logic [3:0] d, input logic [3:0] s, input logic [3:0] t, input logic [9:0] u);
    iss_valid = 1'b1; iss_d = d; iss_s = s; iss_t = t; iss_use = u;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    issue(4'd2, 4'd0, 4'd0, U_TGD | U_TEF);
    tick();
    do_reset();
    n_checks++; if (iss_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_ready: got %b want 1", iss_ready); end
    n_checks++; if (busy_gpr !== 16'h0000) begin n_fail++; $display("FAIL reset_gpr: got %h want 0000", busy_gpr); end
    n_checks++; if (busy_fpr !== 16'h0000) begin n_fail++; $display("FAIL reset_fpr: got %h want 0000", busy_fpr); end
    n_checks++; if (busy_ef !== 1'b0)      begin n_fail++; $display("FAIL reset_ef: got %b want 0", busy_ef); end
    n_checks++; if (stall_cnt !== 4'd0)    begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_raw_waw();
    do_reset();
    issue(4'd3, 4'd1, 4'd2, U_TGD | U_FGS | U_FGT | U_FEF | U_TEF);
    #1;
    n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready: got %b want 1", iss_ready); end
    tick(); idle(); #1;
    n_checks++; if (busy_gpr !== 16'h0008) begin n_fail++; $display("FAIL add_gpr: got %h want 0008", busy_gpr); end
    n_checks++; if (busy_ef !== 1'b1)      begin n_fail++; $display("FAIL add_ef: got %b want 1", busy_ef); end
    issue(4'd3, 4'd0, 4'd0, U_TGD); #1;
    n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL waw_gpr_ready: got %b want 0", iss_ready); end
    issue(4'd0, 4'd0, 4'd0, U_TEF); #1;
    n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL waw_ef_ready: got %b want 0", iss_ready); end
    issue(4'd5, 4'd0, 4'd3, U_TGD | U_FGT); #1;
    n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL mov_raw_ready: got %b want 0", iss_ready); end
    tick();
    n_checks++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL mov_stall1: got %0d want 1", stall_cnt); end
    tick();
    n_checks++; if (stall_cnt !== 4'd2) begin n_fail++; $display("FAIL mov_stall2: got %0d want 2", stall_cnt); end
    wb_g_valid = 1'b1; wb_g_idx = 4'd3; wb_ef_valid = 1'b1; #1;
    n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL mov_bypass_ready: got %b want 1", iss_ready); end
    tick(); idle(); #1;
    n_checks++; if (busy_gpr !== 16'h0020) begin n_fail++; $display("FAIL mov_gpr: got %h want 0020", busy_gpr); end
    n_checks++; if (busy_ef !== 1'b0)      begin n_fail++; $display("FAIL mov_ef: got %b want 0", busy_ef); end
    n_checks++; if (stall_cnt !== 4'd2)    begin n_fail++; $display("FAIL mov_stall_hold: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_set_wins();
    do_reset();
    issue(4'd4, 4'd0, 4'd0, U_TGD);
    tick(); idle(); #1;
    n_checks++; if (busy_gpr !== 16'h0010) begin n_fail++; $display("FAIL l_first_gpr: got %h want 0010", busy_gpr); end
    issue(4'd4, 4'd0, 4'd0, U_TGD); wb_g_valid = 1'b1; wb_g_idx = 4'd4; #1;
    n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL l_bypass_ready: got %b want 1", iss_ready); end
    tick(); idle(); #1;
    n_checks++; if (busy_gpr !== 16'h0010) begin n_fail++; $display("FAIL set_wins_gpr: got %h want 0010", busy_gpr); end
    wb_g_valid = 1'b1; wb_g_idx = 4'd4;
    tick(); idle(); #1;
    n_checks++; if (busy_gpr !== 16'h0000) begin n_fail++; $display("FAIL wb_clear_gpr: got %h want 0000", busy_gpr); end
    wb_g_valid = 1'b1; wb_g_idx = 4'd9;
    tick(); idle(); #1;
    n_checks++; if (busy_gpr !== 16'h0000) begin n_fail++; $display("FAIL wb_nonpend_gpr: got %h want 0000", busy_gpr); end
  endtask

  task automatic test_fpr();
    do_reset();
    issue(4'd7, 4'd0, 4'd0, U_TFD);
    tick(); idle(); #1;
    n_checks++; if (busy_fpr !== 16'h0080) begin n_fail++; $display("FAIL fpr_set: got %h want 0080", busy_fpr); end
    n_checks++; if (busy_gpr !== 16'h0000) begin n_fail++; $display("FAIL fpr_gpr_clean: got %h want 0000", busy_gpr); end
    issue(4'd0, 4'd7, 4'd0, U_FFS); wb_g_valid = 1'b1; wb_g_idx = 4'd7; #1;
    n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL fpr_raw_ready: got %b want 0", iss_ready); end
    tick();
    wb_g_valid = 1'b0; wb_f_valid = 1'b1; wb_f_idx = 4'd7; #1;
    n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL fpr_wb_ready: got %b want 1", iss_ready); end
    tick(); idle(); #1;
    n_checks++; if (busy_fpr !== 16'h0000) begin n_fail++; $display("FAIL fpr_cleared: got %h want 0000", busy_fpr); end
    n_checks++; if (stall_cnt !== 4'd1)    begin n_fail++; $display("FAIL fpr_stall: got %0d want 1", stall_cnt); end
    issue(4'd7, 4'd0, 4'd0, U_TGD);
    tick(); idle();
    issue(4'd0, 4'd7, 4'd7, U_FFS | U_FFD); #1;
    n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL fpr_vs_gpr7_ready: got %b want 1", iss_ready); end
    n_checks++; if (busy_gpr !== 16'h0080) begin n_fail++; $display("FAIL gpr7_pending: got %h want 0080", busy_gpr); end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      issue(4'(i), 4'd0, 4'd0, (i == 0) ? (U_TGD | U_TEF) : U_TGD);
      tick();
    end
    idle(); #1;
    n_checks++; if (busy_gpr !== 16'hFFFF) begin n_fail++; $display("FAIL fill_gpr: got %h want ffff", busy_gpr); end
    n_checks++; if (busy_ef !== 1'b1)      begin n_fail++; $display("FAIL fill_ef: got %b want 1", busy_ef); end
    issue(4'd1, 4'd0, 4'd0, U_TFD); flush = 1'b1; wb_g_valid = 1'b1; wb_g_idx = 4'd2; #1;
    n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", iss_ready); end
    tick(); idle(); #1;
    n_checks++; if (busy_gpr !== 16'h0000) begin n_fail++; $display("FAIL flush_gpr: got %h want 0000", busy_gpr); end
    n_checks++; if (busy_ef !== 1'b0)      begin n_fail++; $display("FAIL flush_ef: got %b want 0", busy_ef); end
    n_checks++; if (busy_fpr !== 16'h0000) begin n_fail++; $display("FAIL flush_no_issue: got %h want 0000", busy_fpr); end
    n_checks++; if (stall_cnt !== 4'd1)    begin n_fail++; $display("FAIL flush_stall: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_stall_sat();
    do_reset();
    issue(4'd3, 4'd0, 4'd0, U_TGD);
    tick();
    for (int i = 0; i < 14; i++) tick();
    n_checks++; if (stall_cnt !== 4'd14) begin n_fail++; $display("FAIL sat_14: got %0d want 14", stall_cnt); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_15_%0d: got %0d want 15", i, stall_cnt); end
    end
    rstn = 1'b0;
    tick();
    n_checks++; if (stall_cnt !== 4'd0)    begin n_fail++; $display("FAIL sat_reset: got %0d want 0", stall_cnt); end
    n_checks++; if (busy_gpr !== 16'h0000) begin n_fail++; $display("FAIL midop_reset_gpr: got %h want 0000", busy_gpr); end
    rstn = 1'b1; idle();
    tick();
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    test_reset();
    test_raw_waw();
    test_set_wins();
    test_fpr();
    test_flush();
    test_stall_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
